spinner_input_arbiter: RTL

//  Arbitrates all paddle sources (PS/2 mouse, USB pulse spinner, analog stick, D-pad, user-port
//  AB encoder) onto the single 2-bit quadrature spinner input of the arkanoid core. Holds a signed

---
 rtl/spinner_input_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spinner_input_arbiter.sv
// spinner_input_arbiter: merges mouse, USB pulse spinner, analog stick, D-pad and (optionally)
// a user-port AB encoder onto the single 2-bit quadrature spinner input of the core.
// A signed accumulator holds pending motion. It is paced out as one quadrature step every
// STEP_DIV cycles.
// Optional feature: define SPINNER_IO_EN to enable the user-port encoder path.
module spinner_input_arbiter #(
  parameter int unsigned ACC_W    = 12,
  parameter int unsigned STEP_DIV = 3000,
  parameter int unsigned POLL_DIV = 96000
) (
  input  logic       clk_12m,
  input  logic       reset,
  input  logic       mouse_strobe,
  input  logic [7:0] mouse_dx,
  input  logic       spin_mode,
  input  logic [1:0] spin_res,
  input  logic       pulse_l,
  input  logic       pulse_r,
  input  logic [7:0] analog_x,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_fast,
  input  logic [1:0] enc_ab,
  output logic [1:0] spinner,
  output logic [2:0] src,
  output logic       busy
);

  localparam int unsigned STEP_W = $clog2(STEP_DIV);
  localparam int unsigned POLL_W = $clog2(POLL_DIV);

  localparam logic [2:0] SRC_MOUSE  = 3'd1;
  localparam logic [2:0] SRC_PULSE  = 3'd2;
  localparam logic [2:0] SRC_ANALOG = 3'd3;
  localparam logic [2:0] SRC_DPAD   = 3'd4;
  localparam logic [2:0] SRC_IO     = 3'd5;

  // Gray-code quadrature walk: forward 00->01->11->10->00, backward is the reverse.
  function automatic logic [1:0] quad_next(input logic [1:0] q, input logic fwd);
    logic [1:0] n;
    unique case (q)
      2'b00:   n = fwd ? 2'b01 : 2'b10;
      2'b01:   n = fwd ? 2'b11 : 2'b00;
      2'b11:   n = fwd ? 2'b10 : 2'b01;
      default: n = fwd ? 2'b00 : 2'b11;
    endcase
    return n;
  endfunction

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]        quad_q, quad_d;
  logic [2:0]        src_q, src_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic              strobe_q;
  logic [1:0]        spinner_q;

  logic              step_wrap;
  logic              pulse_sel, analog_sel, dpad_sel, poll_run, poll_tc;
  logic              load;
  logic [ACC_W-1:0]  load_val;
  logic [2:0]        load_src;
  logic [1:0]        res_eff, shift;
  logic [ACC_W-1:0]  step_mag, dpad_mag, analog_val, mouse_ext;
  logic              mouse_edge, headroom;
  logic              src_claim;   // a load or mouse event takes ownership this cycle
  logic              io_claim;    // encoder activity claims ownership this cycle
  logic [1:0]        spin_mux;

  assign step_wrap  = (step_cnt_q == STEP_W'(STEP_DIV - 1));
  assign res_eff    = (spin_res == 2'd3) ? 2'd2 : spin_res;
  assign shift      = res_eff + {1'b0, btn_fast};
  assign step_mag   = ACC_W'(2) << shift;
  assign dpad_mag   = btn_fast ? ACC_W'(9) : ACC_W'(4);
  // Small deflections whose high nibble is zero still nudge right by one.
  assign analog_val = (analog_x[7:4] == 4'd0) ? ACC_W'(1)
                                              : {{(ACC_W-4){analog_x[7]}}, analog_x[7:4]};
  assign mouse_ext  = {{(ACC_W-8){mouse_dx[7]}}, mouse_dx};

  assign pulse_sel  = spin_mode & (pulse_l | pulse_r);
  assign analog_sel = ~pulse_sel & (analog_x != 8'd0);
  assign dpad_sel   = ~pulse_sel & ~analog_sel & (btn_l | btn_r);
  assign poll_run   = analog_sel | dpad_sel;
  assign poll_tc    = poll_run & (poll_cnt_q == POLL_W'(POLL_DIV - 1));
  assign load       = pulse_sel | poll_tc;

  assign mouse_edge = mouse_strobe ^ strobe_q;
  // Top two bits equal means the value sits in the lower half range, so a mouse delta fits.
  assign headroom   = (acc_q[ACC_W-1] == acc_q[ACC_W-2]);
  assign src_claim  = load | mouse_edge;

  // Pick the load value and owner for whichever source wins this cycle.
  always_comb begin
    load_val = '0;
    load_src = SRC_PULSE;
    if (pulse_sel) begin
      load_val = pulse_r ? step_mag : -step_mag;
      load_src = SRC_PULSE;
    end else if (analog_sel) begin
      load_val = analog_val;
      load_src = SRC_ANALOG;
    end else if (dpad_sel) begin
      load_val = btn_r ? dpad_mag : -dpad_mag;
      load_src = SRC_DPAD;
    end
  end

  // Next state: step engine first, then encoder ownership, then loads / mouse override.
  always_comb begin
    acc_d      = acc_q;
    quad_d     = quad_q;
    src_d      = src_q;
    step_cnt_d = step_wrap ? '0 : step_cnt_q + STEP_W'(1);
    poll_cnt_d = '0;
    if (poll_run) begin
      poll_cnt_d = poll_tc ? '0 : poll_cnt_q + POLL_W'(1);
    end
    if (step_wrap && (acc_q != '0)) begin
      quad_d = quad_next(quad_q, ~acc_q[ACC_W-1]);
      acc_d  = acc_q[ACC_W-1] ? acc_q + ACC_W'(1) : acc_q - ACC_W'(1);
    end
    if (io_claim) begin
      src_d = SRC_IO;
    end
    if (load) begin
      acc_d = load_val;
      src_d = load_src;
    end else if (mouse_edge) begin
      src_d = SRC_MOUSE;
      if (headroom) begin
        acc_d = acc_q + mouse_ext;
      end
    end
  end

  // Core state registers with synchronous reset.
  always_ff @(posedge clk_12m) begin
    if (reset) begin
      acc_q      <= '0;
      quad_q     <= 2'b11;
      src_q      <= '0;
      step_cnt_q <= '0;
      poll_cnt_q <= '0;
      strobe_q   <= mouse_strobe;
      spinner_q  <= 2'b11;
    end else begin
      acc_q      <= acc_d;
      quad_q     <= quad_d;
      src_q      <= src_d;
      step_cnt_q <= step_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      strobe_q   <= mouse_strobe;
      spinner_q  <= spin_mux;
    end
  end

`ifdef SPINNER_IO_EN
  logic [1:0] enc_s1_q, enc_s2_q, enc_q, io_quad_q;
  logic       io_mode_q;
  logic       a_edge;

  assign io_claim = (enc_s2_q != enc_q);
  assign a_edge   = (enc_s2_q[0] != enc_q[0]);
  assign spin_mux = io_mode_q ? io_quad_q : quad_q;

  // Encoder synchroniser, A-edge stepping (halves resolution) and IO ownership flag.
  always_ff @(posedge clk_12m) begin
    if (reset) begin
      enc_s1_q  <= '0;
      enc_s2_q  <= '0;
      enc_q     <= '0;
      io_quad_q <= 2'b11;
      io_mode_q <= 1'b0;
    end else begin
      enc_s1_q <= enc_ab;
      enc_s2_q <= enc_s1_q;
      enc_q    <= enc_s2_q;
      if (a_edge) begin
        io_quad_q <= quad_next(io_quad_q, enc_s2_q[0] ^ enc_s2_q[1]);
      end
      if (src_claim) begin
        io_mode_q <= 1'b0;
      end else if (io_claim) begin
        io_mode_q <= 1'b1;
      end
    end
  end
`else
  logic unused_enc;
  assign unused_enc = ^{enc_ab, src_claim};
  assign io_claim   = 1'b0;
  assign spin_mux   = quad_q;
`endif

  assign spinner = spinner_q;
  assign src     = src_q;
  assign busy    = |acc_q;

endmodule
